// File: rtl/if_id_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_id_stage_pkg
// Shared definitions for the IF/ID pipeline register and its hazard logic:
// RV32I opcode values used for register-source decoding, the default NOP
// encoding, the performance counter width and the FSM state encoding.
// Ports: none (package).
// ----------------------------------------------------------------------------
package if_id_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam int          CNT_W_DEF     = 16;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    // U-type and JAL carry immediate bits in the rs1 field, so they never
    // read rs1 even though the field may hold a nonzero value.
    function automatic logic uses_rs1(input logic [6:0] opc);
        return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/if_id_stage_hazard_detect.sv
// ----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use hazard detector for the instruction held in IF/ID.
// Ports:
//   INSTRUCTION_ID  in  32  instruction currently in IF/ID
//   VALID_ID        in  1   IF/ID holds a real instruction (0 = bubble)
//   ID_EX_MemRead   in  1   instruction in ID/EX is a load
//   ID_EX_rd        in  5   destination register of the ID/EX instruction
//   haz             out 1   load-use hazard present
// ----------------------------------------------------------------------------
module hazard_detect
    import if_id_stage_pkg::*;
(
    input  logic [31:0] INSTRUCTION_ID,
    input  logic        VALID_ID,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_rd,
    output logic        haz
);

    logic [6:0] opc;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_hit;
    logic       rs2_hit;

    assign opc = INSTRUCTION_ID[6:0];
    assign rs1 = INSTRUCTION_ID[19:15];
    assign rs2 = INSTRUCTION_ID[24:20];

    // funct fields, immediates and rd play no part in the hazard decision
    logic unused_instr_bits;
    assign unused_instr_bits = ^{INSTRUCTION_ID[31:25], INSTRUCTION_ID[14:7]};

    assign rs1_hit = uses_rs1(opc) && (ID_EX_rd == rs1);
    assign rs2_hit = uses_rs2(opc) && (ID_EX_rd == rs2);

    // x0 is never a real dependency; bubbles never stall
    assign haz = VALID_ID && ID_EX_MemRead && (ID_EX_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/if_id_stage.sv
// ----------------------------------------------------------------------------
// if_id_stage
// IF/ID pipeline register with load-use stall and branch flush control.
// Registers PC/instruction from fetch, holds them for one cycle on a load-use
// hazard (PC_write low, bubble into ID/EX), replaces them with a NOP bubble on
// a taken branch, and keeps saturating stall/flush counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_RUN   | normal flow; a hazard here stalls fetch for one cycle
// ST_STALL | the single stall cycle has been taken; hazard ignored, reload
//
// Ports:
//   clk, reset (async, active-low)
//   PC_IF, INSTRUCTION_IF        fetch-stage PC and instruction
//   PCSrc                        taken branch / flush request
//   ID_EX_MemRead, ID_EX_rd      load in ID/EX and its destination
//   PC_write, stall_ID           combinational fetch enable / ID-EX bubble
//   PC_ID, INSTRUCTION_ID, VALID_ID, RS1_ID, RS2_ID, RD_ID   IF/ID contents
//   stall_cnt, flush_cnt         saturating performance counters
// ----------------------------------------------------------------------------
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter int          CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      PC_IF,
    input  logic [31:0]      INSTRUCTION_IF,
    input  logic             PCSrc,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rd,
    output logic             PC_write,
    output logic             stall_ID,
    output logic [31:0]      PC_ID,
    output logic [31:0]      INSTRUCTION_ID,
    output logic             VALID_ID,
    output logic [4:0]       RS1_ID,
    output logic [4:0]       RS2_ID,
    output logic [4:0]       RD_ID,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              haz;

    hazard_detect u_hazard_detect (
        .INSTRUCTION_ID (instr_q),
        .VALID_ID       (valid_q),
        .ID_EX_MemRead  (ID_EX_MemRead),
        .ID_EX_rd       (ID_EX_rd),
        .haz            (haz)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        PC_write = 1'b1;
        stall_ID = 1'b0;

        if (PCSrc) begin
            // flush wins over a pending stall in either state
            pc_d    = PC_IF;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (haz) begin
                        PC_write = 1'b0;
                        stall_ID = 1'b1;
                        state_d  = ST_STALL;
                    end else begin
                        pc_d    = PC_IF;
                        instr_d = INSTRUCTION_IF;
                        valid_d = 1'b1;
                    end
                end
                ST_STALL: begin
                    // hazard still visible this cycle is the same pair; reload
                    pc_d    = PC_IF;
                    instr_d = INSTRUCTION_IF;
                    valid_d = 1'b1;
                    state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_ID && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (PCSrc && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            pc_q        <= 32'd0;
            instr_q     <= NOP_INSTR;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign PC_ID          = pc_q;
    assign INSTRUCTION_ID = instr_q;
    assign VALID_ID       = valid_q;
    assign RS1_ID         = instr_q[19:15];
    assign RS2_ID         = instr_q[24:20];
    assign RD_ID          = instr_q[11:7];
    assign stall_cnt      = stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// ----------------------------------------------------------------------------
// tb_if_id_stage
// Directed self-checking bench for if_id_stage. Inputs change 1 time unit
// after the rising edge; outputs are sampled a further unit later.
// ----------------------------------------------------------------------------
module tb_if_id_stage;

    localparam logic [31:0] I_NOP  = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] I_ADDI = 32'h0050_0093;  // addi x1,x0,5  (rs2 field=5)
    localparam logic [31:0] I_ADD  = 32'h0020_81B3;  // add  x3,x1,x2
    localparam logic [31:0] I_ADD2 = 32'h0030_8233;  // add  x4,x1,x3
    localparam logic [31:0] I_LUI  = 32'h0000_80B7;  // lui  x1,8     (rs1 field=1)
    localparam logic [31:0] I_SW   = 32'h0022_A023;  // sw   x2,0(x5)

    logic        clk;
    logic        reset;
    logic [31:0] PC_IF;
    logic [31:0] INSTRUCTION_IF;
    logic        PCSrc;
    logic        ID_EX_MemRead;
    logic [4:0]  ID_EX_rd;
    logic        PC_write;
    logic        stall_ID;
    logic [31:0] PC_ID;
    logic [31:0] INSTRUCTION_ID;
    logic        VALID_ID;
    logic [4:0]  RS1_ID;
    logic [4:0]  RS2_ID;
    logic [4:0]  RD_ID;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    if_id_stage dut (
        .clk            (clk),
        .reset          (reset),
        .PC_IF          (PC_IF),
        .INSTRUCTION_IF (INSTRUCTION_IF),
        .PCSrc          (PCSrc),
        .ID_EX_MemRead  (ID_EX_MemRead),
        .ID_EX_rd       (ID_EX_rd),
        .PC_write       (PC_write),
        .stall_ID       (stall_ID),
        .PC_ID          (PC_ID),
        .INSTRUCTION_ID (INSTRUCTION_ID),
        .VALID_ID       (VALID_ID),
        .RS1_ID         (RS1_ID),
        .RS2_ID         (RS2_ID),
        .RD_ID          (RD_ID),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_id(input logic [31:0] pc, input logic [31:0] instr);
        ID_EX_MemRead  = 1'b0;
        PCSrc          = 1'b0;
        PC_IF          = pc;
        INSTRUCTION_IF = instr;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b0; PC_IF = 32'hdead_beef; INSTRUCTION_IF = I_ADD;
        PCSrc = 1'b0; ID_EX_MemRead = 1'b0; ID_EX_rd = 5'd0;
        tick(); tick(); #1;
        chk_cnt++; if (PC_ID !== 32'd0) $display("FAIL rst_pc got %h exp %h", PC_ID, 32'd0); else pass_cnt++;
        chk_cnt++; if (INSTRUCTION_ID !== I_NOP) $display("FAIL rst_instr got %h exp %h", INSTRUCTION_ID, I_NOP); else pass_cnt++;
        chk_cnt++; if (VALID_ID !== 1'b0) $display("FAIL rst_valid got %b exp 0", VALID_ID); else pass_cnt++;
        chk_cnt++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) $display("FAIL rst_cnt got %h/%h exp 0/0", stall_cnt, flush_cnt); else pass_cnt++;
        chk_cnt++; if (PC_write !== 1'b1 || stall_ID !== 1'b0) $display("FAIL rst_ctl got pcw=%b st=%b exp 1/0", PC_write, stall_ID); else pass_cnt++;
    endtask

    task automatic test_load;
        @(posedge clk); #1;
        reset = 1'b1; PC_IF = 32'd0; INSTRUCTION_IF = I_ADDI;
        tick(); #1;
        chk_cnt++; if (PC_ID !== 32'd0) $display("FAIL load_pc got %h exp 0", PC_ID); else pass_cnt++;
        chk_cnt++; if (INSTRUCTION_ID !== I_ADDI) $display("FAIL load_instr got %h exp %h", INSTRUCTION_ID, I_ADDI); else pass_cnt++;
        chk_cnt++; if (VALID_ID !== 1'b1) $display("FAIL load_valid got %b exp 1", VALID_ID); else pass_cnt++;
        chk_cnt++; if (RD_ID !== 5'd1 || RS1_ID !== 5'd0 || RS2_ID !== 5'd5) $display("FAIL load_fields got rd=%0d rs1=%0d rs2=%0d exp 1/0/5", RD_ID, RS1_ID, RS2_ID); else pass_cnt++;
        load_id(32'h4, I_ADD); #1;
        chk_cnt++; if (PC_ID !== 32'h4 || RS1_ID !== 5'd1 || RS2_ID !== 5'd2 || RD_ID !== 5'd3) $display("FAIL load_add got pc=%h rs1=%0d rs2=%0d rd=%0d exp 4/1/2/3", PC_ID, RS1_ID, RS2_ID, RD_ID); else pass_cnt++;
    endtask

    task automatic test_load_use;
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd1; PC_IF = 32'h8; INSTRUCTION_IF = I_NOP;
        #1;
        chk_cnt++; if (PC_write !== 1'b0 || stall_ID !== 1'b1) $display("FAIL lu_ctl got pcw=%b st=%b exp 0/1", PC_write, stall_ID); else pass_cnt++;
        tick(); #1;
        chk_cnt++; if (INSTRUCTION_ID !== I_ADD || PC_ID !== 32'h4) $display("FAIL lu_hold got %h@%h exp %h@4", INSTRUCTION_ID, PC_ID, I_ADD); else pass_cnt++;
        chk_cnt++; if (stall_cnt !== 16'd1) $display("FAIL lu_cnt got %0d exp 1", stall_cnt); else pass_cnt++;
        chk_cnt++; if (PC_write !== 1'b1 || stall_ID !== 1'b0) $display("FAIL lu_release got pcw=%b st=%b exp 1/0", PC_write, stall_ID); else pass_cnt++;
        tick(); #1;
        chk_cnt++; if (INSTRUCTION_ID !== I_NOP || PC_ID !== 32'h8 || stall_cnt !== 16'd1) $display("FAIL lu_resume got %h@%h cnt=%0d exp %h@8 cnt=1", INSTRUCTION_ID, PC_ID, stall_cnt, I_NOP); else pass_cnt++;
        ID_EX_MemRead = 1'b0;
    endtask

    task automatic test_no_hazard;
        load_id(32'hC, I_ADD);
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd0; #1;
        chk_cnt++; if (PC_write !== 1'b1 || stall_ID !== 1'b0) $display("FAIL nh_x0 got pcw=%b st=%b exp 1/0", PC_write, stall_ID); else pass_cnt++;
        ID_EX_rd = 5'd2; #1;
        chk_cnt++; if (stall_ID !== 1'b1) $display("FAIL nh_add_rs2 got st=%b exp 1", stall_ID); else pass_cnt++;
        ID_EX_MemRead = 1'b0; #1;
        chk_cnt++; if (stall_ID !== 1'b0 || PC_write !== 1'b1) $display("FAIL nh_noload got pcw=%b st=%b exp 1/0", PC_write, stall_ID); else pass_cnt++;
        load_id(32'h10, I_LUI);
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd1; #1;
        chk_cnt++; if (PC_write !== 1'b1 || stall_ID !== 1'b0) $display("FAIL nh_lui got pcw=%b st=%b exp 1/0", PC_write, stall_ID); else pass_cnt++;
        load_id(32'h14, I_ADDI);
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd5; #1;
        chk_cnt++; if (stall_ID !== 1'b0) $display("FAIL nh_addi_rs2 got st=%b exp 0", stall_ID); else pass_cnt++;
        load_id(32'h18, I_SW);
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd2; #1;
        chk_cnt++; if (stall_ID !== 1'b1 || PC_write !== 1'b0) $display("FAIL nh_sw_rs2 got pcw=%b st=%b exp 0/1", PC_write, stall_ID); else pass_cnt++;
        ID_EX_rd = 5'd5; #1;
        chk_cnt++; if (stall_ID !== 1'b1) $display("FAIL nh_sw_rs1 got st=%b exp 1", stall_ID); else pass_cnt++;
        ID_EX_MemRead = 1'b0;
    endtask

    task automatic test_flush;
        load_id(32'h1C, I_ADD);
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd1; PCSrc = 1'b1; PC_IF = 32'h40; INSTRUCTION_IF = I_ADD2; #1;
        chk_cnt++; if (PC_write !== 1'b1 || stall_ID !== 1'b0) $display("FAIL fl_ctl got pcw=%b st=%b exp 1/0", PC_write, stall_ID); else pass_cnt++;
        tick(); #1;
        chk_cnt++; if (INSTRUCTION_ID !== I_NOP || VALID_ID !== 1'b0 || PC_ID !== 32'h40) $display("FAIL fl_bubble got %h v=%b @%h exp %h v=0 @40", INSTRUCTION_ID, VALID_ID, PC_ID, I_NOP); else pass_cnt++;
        chk_cnt++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) $display("FAIL fl_cnt got f=%0d s=%0d exp 1/1", flush_cnt, stall_cnt); else pass_cnt++;
        PCSrc = 1'b0; PC_IF = 32'h44; INSTRUCTION_IF = I_ADD; #1;
        chk_cnt++; if (stall_ID !== 1'b0 || PC_write !== 1'b1) $display("FAIL fl_bubble_nohaz got pcw=%b st=%b exp 1/0", PC_write, stall_ID); else pass_cnt++;
        tick(); #1;
        chk_cnt++; if (stall_ID !== 1'b1) $display("FAIL fl_rehaz got st=%b exp 1", stall_ID); else pass_cnt++;
        tick();
        PCSrc = 1'b1; PC_IF = 32'h80; INSTRUCTION_IF = I_ADD2; #1;
        chk_cnt++; if (stall_cnt !== 16'd2 || PC_write !== 1'b1 || stall_ID !== 1'b0) $display("FAIL fl_in_stall got s=%0d pcw=%b st=%b exp 2/1/0", stall_cnt, PC_write, stall_ID); else pass_cnt++;
        tick(); #1;
        chk_cnt++; if (PC_ID !== 32'h80 || VALID_ID !== 1'b0 || flush_cnt !== 16'd2 || stall_cnt !== 16'd2) $display("FAIL fl_from_stall got pc=%h v=%b f=%0d s=%0d exp 80/0/2/2", PC_ID, VALID_ID, flush_cnt, stall_cnt); else pass_cnt++;
        PCSrc = 1'b0; PC_IF = 32'h84; INSTRUCTION_IF = I_ADD;
        tick(); #1;
        chk_cnt++; if (INSTRUCTION_ID !== I_ADD || stall_ID !== 1'b1) $display("FAIL fl_after got %h st=%b exp %h st=1", INSTRUCTION_ID, stall_ID, I_ADD); else pass_cnt++;
        ID_EX_MemRead = 1'b0;
    endtask

    task automatic test_back_to_back;
        load_id(32'h100, I_ADD);
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd1; PC_IF = 32'h104; INSTRUCTION_IF = I_ADD2;
        tick(); #1;
        chk_cnt++; if (stall_cnt !== 16'd3 || INSTRUCTION_ID !== I_ADD || stall_ID !== 1'b0) $display("FAIL b2b_first got s=%0d %h st=%b exp 3 %h 0", stall_cnt, INSTRUCTION_ID, stall_ID, I_ADD); else pass_cnt++;
        tick(); #1;
        chk_cnt++; if (INSTRUCTION_ID !== I_ADD2 || PC_ID !== 32'h104 || stall_ID !== 1'b1) $display("FAIL b2b_second got %h@%h st=%b exp %h@104 st=1", INSTRUCTION_ID, PC_ID, stall_ID, I_ADD2); else pass_cnt++;
        PC_IF = 32'h108; INSTRUCTION_IF = I_NOP;
        tick(); #1;
        chk_cnt++; if (stall_cnt !== 16'd4 || INSTRUCTION_ID !== I_ADD2) $display("FAIL b2b_hold got s=%0d %h exp 4 %h", stall_cnt, INSTRUCTION_ID, I_ADD2); else pass_cnt++;
        tick(); #1;
        chk_cnt++; if (INSTRUCTION_ID !== I_NOP || PC_ID !== 32'h108 || stall_cnt !== 16'd4) $display("FAIL b2b_done got %h@%h s=%0d exp %h@108 4", INSTRUCTION_ID, PC_ID, stall_cnt, I_NOP); else pass_cnt++;
        ID_EX_MemRead = 1'b0;
    endtask

    task automatic test_saturate;
        load_id(32'h200, I_ADD);
        force dut.stall_cnt_q = 16'hFFFF;
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd1; #1;
        chk_cnt++; if (stall_ID !== 1'b1) $display("FAIL sat_haz got st=%b exp 1", stall_ID); else pass_cnt++;
        tick();
        release dut.stall_cnt_q;
        #1;
        chk_cnt++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_hold got %h exp ffff", stall_cnt); else pass_cnt++;
        tick(); #1;
        chk_cnt++; if (stall_cnt !== 16'hFFFF || flush_cnt !== 16'd2) $display("FAIL sat_after got s=%h f=%0d exp ffff/2", stall_cnt, flush_cnt); else pass_cnt++;
        ID_EX_MemRead = 1'b0;
    endtask

    task automatic test_reset_mid_stall;
        load_id(32'h300, I_ADD);
        ID_EX_MemRead = 1'b1; ID_EX_rd = 5'd1;
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk_cnt++; if (VALID_ID !== 1'b0 || INSTRUCTION_ID !== I_NOP || PC_ID !== 32'd0) $display("FAIL mrst_ifid got v=%b %h@%h exp 0 %h@0", VALID_ID, INSTRUCTION_ID, PC_ID, I_NOP); else pass_cnt++;
        chk_cnt++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) $display("FAIL mrst_cnt got %h/%h exp 0/0", stall_cnt, flush_cnt); else pass_cnt++;
        tick();
        reset = 1'b1; PC_IF = 32'h304; INSTRUCTION_IF = I_ADD; #1;
        chk_cnt++; if (PC_write !== 1'b1 || stall_ID !== 1'b0) $display("FAIL mrst_release got pcw=%b st=%b exp 1/0", PC_write, stall_ID); else pass_cnt++;
        tick(); #1;
        chk_cnt++; if (VALID_ID !== 1'b1 || PC_ID !== 32'h304 || stall_ID !== 1'b1) $display("FAIL mrst_resume got v=%b pc=%h st=%b exp 1/304/1", VALID_ID, PC_ID, stall_ID); else pass_cnt++;
        ID_EX_MemRead = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_load_use();
        test_no_hazard();
        test_flush();
        test_back_to_back();
        test_saturate();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
